// File: rtl/control_unit_pkg.sv
// Shared constants for the RV32I control unit: opcodes, ALU operation
// encoding and immediate-format encoding.
package control_unit_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU operation select
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Immediate format select (S vs B is split downstream by opcode bit 6)
  localparam logic IMM_I  = 1'b0;
  localparam logic IMM_SB = 1'b1;

endpackage

// File: rtl/control_unit_alu_op_decode.sv
// Arithmetic funct3 / alternate-bit to ALU operation mapping. The caller
// masks alt so that it only reaches here when it is meaningful.
module alu_op_decode
  import control_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alt,
  output logic [3:0] alu_op
);

  // Map funct3 (plus alternate bit for ADD/SUB and SRL/SRA) to ALUop
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000: begin
        if (alt) alu_op = ALU_SUB;
        else     alu_op = ALU_ADD;
      end
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      3'b101: begin
        if (alt) alu_op = ALU_SRA;
        else     alu_op = ALU_SRL;
      end
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I single-cycle control unit: decodes the instruction and comparator
// flags and presents every control signal from a register (1-cycle latency).
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        BrEq,
  input  logic        BrLt,
  input  logic [31:0] I,
  output logic [3:0]  ALUop,
  output logic        wEn,
  output logic        ImmSel,
  output logic        BSel,
  output logic        BrUn,
  output logic        ASel,
  output logic        PCSel,
  output logic        WBSel,
  output logic        MemRW
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [4:0] rd_s;
  logic       is_r_s;
  logic       alt_s;
  logic [3:0] arith_op_s;
  logic       rd_nz_s;
  logic       taken_s;

  logic [3:0] alu_op_s;
  logic       wen_s, immsel_s, bsel_s, brun_s, asel_s, pcsel_s, wbsel_s, memrw_s;

  // Instruction bits not consumed by control decode
  logic       unused_s;
  assign unused_s = ^{I[31], I[29:15]};

  assign opcode_s = I[6:0];
  assign funct3_s = I[14:12];
  assign rd_s     = I[11:7];
  assign is_r_s   = (opcode_s == OPC_RTYPE);
  assign rd_nz_s  = (rd_s != 5'd0);

  // Alternate bit picks SUB only for R-type; picks SRA for both R and I-type
  always_comb begin
    if (is_r_s) alt_s = I[30];
    else        alt_s = I[30] & (funct3_s == 3'b101);
  end

  alu_op_decode u_alu_op_decode (
    .funct3 (funct3_s),
    .alt    (alt_s),
    .alu_op (arith_op_s)
  );

  // Branch resolution from funct3 and comparator flags
  always_comb begin
    taken_s = 1'b0;
    case (funct3_s)
      3'b000:  taken_s = BrEq;
      3'b001:  taken_s = ~BrEq;
      3'b100:  taken_s = BrLt;
      3'b101:  taken_s = ~BrLt;
      3'b110:  taken_s = BrLt;
      3'b111:  taken_s = ~BrLt;
      default: taken_s = 1'b0;
    endcase
  end

  // Opcode decode into next-cycle control values; unknown opcodes give NOP
  always_comb begin
    alu_op_s = ALU_ADD;
    wen_s    = 1'b0;
    immsel_s = IMM_I;
    bsel_s   = 1'b0;
    brun_s   = 1'b0;
    asel_s   = 1'b0;
    pcsel_s  = 1'b0;
    wbsel_s  = 1'b0;
    memrw_s  = 1'b0;
    case (opcode_s)
      OPC_RTYPE: begin
        alu_op_s = arith_op_s;
        wen_s    = rd_nz_s;
      end
      OPC_ITYPE: begin
        alu_op_s = arith_op_s;
        bsel_s   = 1'b1;
        immsel_s = IMM_I;
        wen_s    = rd_nz_s;
      end
      OPC_LOAD: begin
        bsel_s   = 1'b1;
        immsel_s = IMM_I;
        wen_s    = rd_nz_s;
        wbsel_s  = 1'b1;
      end
      OPC_STORE: begin
        bsel_s   = 1'b1;
        immsel_s = IMM_SB;
        memrw_s  = 1'b1;
      end
      OPC_BRANCH: begin
        asel_s   = 1'b1;
        bsel_s   = 1'b1;
        immsel_s = IMM_SB;
        brun_s   = funct3_s[1];
        pcsel_s  = taken_s;
      end
      default: begin
        alu_op_s = ALU_ADD;
        wen_s    = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears everything to the NOP value immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUop  <= ALU_ADD;
      wEn    <= 1'b0;
      ImmSel <= 1'b0;
      BSel   <= 1'b0;
      BrUn   <= 1'b0;
      ASel   <= 1'b0;
      PCSel  <= 1'b0;
      WBSel  <= 1'b0;
      MemRW  <= 1'b0;
    end else begin
      ALUop  <= alu_op_s;
      wEn    <= wen_s;
      ImmSel <= immsel_s;
      BSel   <= bsel_s;
      BrUn   <= brun_s;
      ASel   <= asel_s;
      PCSel  <= pcsel_s;
      WBSel  <= wbsel_s;
      MemRW  <= memrw_s;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, hand-written
// reset/latency sequences, and random instructions against a reference model.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        BrEq;
  logic        BrLt;
  logic [31:0] I;
  logic [3:0]  ALUop;
  logic        wEn, ImmSel, BSel, BrUn, ASel, PCSel, WBSel, MemRW;

  int checks;
  int failures;

  control_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .BrEq   (BrEq),
    .BrLt   (BrLt),
    .I      (I),
    .ALUop  (ALUop),
    .wEn    (wEn),
    .ImmSel (ImmSel),
    .BSel   (BSel),
    .BrUn   (BrUn),
    .ASel   (ASel),
    .PCSel  (PCSel),
    .WBSel  (WBSel),
    .MemRW  (MemRW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {ALUop, wEn, ImmSel, BSel, BrUn, ASel, PCSel, WBSel, MemRW}
  logic [11:0] outs;
  assign outs = {ALUop, wEn, ImmSel, BSel, BrUn, ASel, PCSel, WBSel, MemRW};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        eq;
    logic        lt;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model built from the RV32I instruction-set rules
  function automatic logic [11:0] model(input logic [31:0] ins, input logic eq, input logic lt);
    logic [3:0] tbl [0:7];
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] alu;
    logic       we, imm, b, un, a, pc, wb, mw, rd_ok, cond;
    tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    op = ins[6:0];
    f3 = ins[14:12];
    rd_ok = (ins[11:7] != 5'd0);
    alu = 4'd0; we = 1'b0; imm = 1'b0; b = 1'b0; un = 1'b0;
    a = 1'b0; pc = 1'b0; wb = 1'b0; mw = 1'b0;
    if (op == 7'h33 || op == 7'h13) begin
      alu = tbl[f3];
      if (ins[30] && f3 == 3'd5) alu = alu + 4'd1;
      if (ins[30] && f3 == 3'd0 && op == 7'h33) alu = alu + 4'd1;
      we = rd_ok;
      b = (op == 7'h13);
    end else if (op == 7'h03) begin
      we = rd_ok; b = 1'b1; wb = 1'b1;
    end else if (op == 7'h23) begin
      b = 1'b1; imm = 1'b1; mw = 1'b1;
    end else if (op == 7'h63) begin
      a = 1'b1; b = 1'b1; imm = 1'b1; un = f3[1];
      cond = (f3[2] ? lt : eq) ^ f3[0];
      pc = (f3 == 3'd2 || f3 == 3'd3) ? 1'b0 : cond;
    end
    return {alu, we, imm, b, un, a, pc, wb, mw};
  endfunction

  logic [11:0] prev_exp;
  logic [6:0]  opc_pool [0:5];

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    BrEq = 1'b0;
    BrLt = 1'b0;
    I = 32'h00000000;

    // Directed vectors: name, instruction, BrEq, BrLt, expected outputs
    vecs.push_back('{"load_rd0",   32'h00000003, 1'b0, 1'b0, 12'b0000_0_0_1_0_0_0_1_0});
    vecs.push_back('{"load_rd1",   32'h00000083, 1'b0, 1'b0, 12'b0000_1_0_1_0_0_0_1_0});
    vecs.push_back('{"store",      32'h00000023, 1'b0, 1'b0, 12'b0000_0_1_1_0_0_0_0_1});
    vecs.push_back('{"r_xor",      32'h000040B3, 1'b0, 1'b0, 12'b0100_1_0_0_0_0_0_0_0});
    vecs.push_back('{"r_or",       32'h000060B3, 1'b0, 1'b0, 12'b0011_1_0_0_0_0_0_0_0});
    vecs.push_back('{"r_and",      32'h000070B3, 1'b0, 1'b0, 12'b0010_1_0_0_0_0_0_0_0});
    vecs.push_back('{"r_sll",      32'h000010B3, 1'b0, 1'b0, 12'b0101_1_0_0_0_0_0_0_0});
    vecs.push_back('{"r_srl",      32'h000050B3, 1'b0, 1'b0, 12'b0110_1_0_0_0_0_0_0_0});
    vecs.push_back('{"r_add",      32'h000000B3, 1'b0, 1'b0, 12'b0000_1_0_0_0_0_0_0_0});
    vecs.push_back('{"r_sub",      32'h400000B3, 1'b0, 1'b0, 12'b0001_1_0_0_0_0_0_0_0});
    vecs.push_back('{"r_sra",      32'h400050B3, 1'b0, 1'b0, 12'b0111_1_0_0_0_0_0_0_0});
    vecs.push_back('{"r_add_rd0",  32'h00000033, 1'b0, 1'b0, 12'b0000_0_0_0_0_0_0_0_0});
    vecs.push_back('{"i_srai",     32'h40005093, 1'b0, 1'b0, 12'b0111_1_0_1_0_0_0_0_0});
    vecs.push_back('{"i_addi_alt", 32'h40000093, 1'b0, 1'b0, 12'b0000_1_0_1_0_0_0_0_0});
    vecs.push_back('{"beq_taken",  32'h00000063, 1'b1, 1'b0, 12'b0000_0_1_1_0_1_1_0_0});
    vecs.push_back('{"beq_not",    32'h00000063, 1'b0, 1'b0, 12'b0000_0_1_1_0_1_0_0_0});
    vecs.push_back('{"bgeu_taken", 32'h00007063, 1'b0, 1'b0, 12'b0000_0_1_1_1_1_1_0_0});
    vecs.push_back('{"br_f3_010",  32'h00002063, 1'b1, 1'b1, 12'b0000_0_1_1_1_1_0_0_0});
    vecs.push_back('{"nop_7f",     32'h00000FFF, 1'b1, 1'b1, 12'b0000_0_0_0_0_0_0_0_0});

    // Reset state
    step();
    chk("reset_state", outs, 12'h000);
    rst_n = 1'b1;
    chk("reset_release_hold", outs, 12'h000);

    // Directed table, also confirming each result waits for the clock edge
    prev_exp = 12'h000;
    for (int k = 0; k < vecs.size(); k++) begin
      I = vecs[k].instr;
      BrEq = vecs[k].eq;
      BrLt = vecs[k].lt;
      #1;
      chk({vecs[k].name, "_pre_edge"}, outs, prev_exp);
      step();
      chk(vecs[k].name, outs, vecs[k].exp);
      prev_exp = vecs[k].exp;
    end

    // Mid-stream reset clears outputs without a clock edge
    I = 32'h00000083;
    step();
    chk("pre_reset_load", outs, 12'b0000_1_0_1_0_0_0_1_0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear", outs, 12'h000);
    step();
    chk("reset_held", outs, 12'h000);
    rst_n = 1'b1;
    #1;
    chk("release_no_edge", outs, 12'h000);
    step();
    chk("first_after_release", outs, 12'b0000_1_0_1_0_0_0_1_0);

    // Random instructions against the reference model
    opc_pool = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
    prev_exp = model(I, BrEq, BrLt);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r;
      logic [11:0] e;
      r = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        r[6:0] = opc_pool[$urandom_range(0, 4)];
      end
      I = r;
      BrEq = 1'($urandom_range(0, 1));
      BrLt = 1'($urandom_range(0, 1));
      e = model(r, BrEq, BrLt);
      #1;
      if (n % 10 == 0) chk("rand_pre_edge", outs, prev_exp);
      step();
      chk($sformatf("rand_%08h_eq%0d_lt%0d", r, BrEq, BrLt), outs, e);
      prev_exp = e;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
